// File: rtl/scoreboard_issue_unit.sv
// Scoreboard consumer: launches the head instruction into a free in-flight slot, then commits or flushes it.
// Optional issue/commit/flush counters are enabled by defining ISSUE_STATS_EN.
module scoreboard_issue_unit #(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned LAT_ALU   = 1,
  parameter int unsigned LAT_MUL   = 3,
  parameter int unsigned LAT_MEM   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] head_instr,
  input  logic        head_ready,
  input  logic        stall_issue,
  input  logic        flushing_instr,
  input  logic [31:0] instr_to_flush,
  output logic        start_head,
  output logic        committing_instr,
  output logic [31:0] instr_to_finish,
  output logic        slots_full,
  output logic        busy
`ifdef ISSUE_STATS_EN
  ,
  output logic [31:0] issued_count,
  output logic [31:0] committed_count,
  output logic [31:0] flushed_count
`endif
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned INSN_W = 32;

  logic [NUM_SLOTS-1:0] valid_q, valid_d;
  logic [INSN_W-1:0]    instr_q [NUM_SLOTS];
  logic [INSN_W-1:0]    instr_d [NUM_SLOTS];
  logic [CNT_W-1:0]     cnt_q   [NUM_SLOTS];
  logic [CNT_W-1:0]     cnt_d   [NUM_SLOTS];
  logic                 out_en_q;

  logic [NUM_SLOTS-1:0] flush_hit, done, commit_oh, free_oh;
  logic                 commit_found, free_found;
  logic [INSN_W-1:0]    commit_instr;

  // Countdown preset (latency minus one) decoded from the instruction word.
  function automatic logic [CNT_W-1:0] lat_preset(input logic [INSN_W-1:0] ins);
    if (ins[6:0] == 7'b0110011 && ins[31:25] == 7'b0000001) return CNT_W'(LAT_MUL - 1);
    if (ins[6:0] == 7'b0000011 || ins[6:0] == 7'b0100011)   return CNT_W'(LAT_MEM - 1);
    return CNT_W'(LAT_ALU - 1);
  endfunction

  // Lowest-index done slot for commit and lowest-index free slot for start.
  always_comb begin
    flush_hit    = '0;
    done         = '0;
    commit_oh    = '0;
    free_oh      = '0;
    commit_found = 1'b0;
    free_found   = 1'b0;
    commit_instr = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      flush_hit[i] = flushing_instr & valid_q[i] & (instr_q[i] == instr_to_flush);
      done[i]      = valid_q[i] & (cnt_q[i] == '0) & ~flush_hit[i];
      if (done[i] && !commit_found) begin
        commit_found = 1'b1;
        commit_oh[i] = 1'b1;
        commit_instr = instr_q[i];
      end
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_oh[i] = 1'b1;
      end
    end
  end

  assign slots_full       = &valid_q;
  assign busy             = |valid_q;
  assign committing_instr = commit_found;
  assign instr_to_finish  = commit_found ? commit_instr : '0;
  // out_en_q holds off starts for the first cycle after reset release.
  assign start_head = out_en_q & head_ready & (head_instr != '0) & ~slots_full & ~stall_issue
                    & ~(flushing_instr & (head_instr == instr_to_flush));

  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      instr_d[i] = instr_q[i];
      cnt_d[i]   = cnt_q[i];
      if (flush_hit[i] || commit_oh[i]) begin
        valid_d[i] = 1'b0;
        instr_d[i] = '0;
        cnt_d[i]   = '0;
      end else if (valid_q[i] && cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
      if (start_head && free_oh[i]) begin
        valid_d[i] = 1'b1;
        instr_d[i] = head_instr;
        cnt_d[i]   = lat_preset(head_instr);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q  <= '0;
      out_en_q <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        instr_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      out_en_q <= 1'b1;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        instr_q[i] <= instr_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

`ifdef ISSUE_STATS_EN
  logic [CNT_W-1:0] flush_cnt;

  always_comb begin
    flush_cnt = '0;
    for (int i = 0; i < NUM_SLOTS; i++) flush_cnt = flush_cnt + CNT_W'(flush_hit[i]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      issued_count    <= '0;
      committed_count <= '0;
      flushed_count   <= '0;
    end else begin
      issued_count    <= issued_count + 32'(start_head);
      committed_count <= committed_count + 32'(committing_instr);
      flushed_count   <= flushed_count + 32'(flush_cnt);
    end
  end
`endif

endmodule
